freq_counter_wb: RTL and testbench
==================================

Name: freq_counter_wb

Overview:
Reciprocal frequency counter with a Wishbone-style slave register interface.
- Measures the time spanned by GATE_EDGES consecutive periods of `signal_input`, counted in `clk_i` cycles.
- Software reads the result and derives f = GATE_EDGES × f_clk / count.
- Sits on the peripheral bus as a memory-mapped measurement block.

Parameters:
- GATE_EDGES, 8: number of signal_input periods per measurement (1..255).
- SYNC_STAGES, 2: synchronizer depth for signal_input.

Ports:
- clk_i  in  1  system clock; all logic runs on its rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- addr_i  in  32  register address.
- dat_i  in  32  write data.
- dat_o  out  32  read data.
- we_i  in  1  write enable.
- sel_i  in  4  byte selects; ignored, all accesses are full-word.
- cyc_i  in  1  bus cycle; ignored, transfers are qualified by stb_i alone.
- stb_i  in  1  transfer strobe.
- lock_i  in  1  ignored.
- err_o  out  1  error: strobe to an unmapped address.
- rty_o  out  1  always 0.
- ack_o  out  1  transfer acknowledge.
- tagn_i  in  1  tag in.
- tagn_o  out  1  registered copy of tagn_i.
- signal_input  in  1  asynchronous signal to measure.
- reference_clk_main  in  1  reserved, unused; the time base is clk_i.
- reference_clk_interpolate  in  1  reserved, unused.

Behaviour:
- Reset: state IDLE, ref_cnt=0, edge_cnt=0, done=0, tagn_o=0, synchronizer flops 0.
- Outputs are combinational from registers, so they read 0 during reset.
- Bus decode uses the full addr_i:
  - 0x08 CTRL (W).
  - 0x09 RESULT (R): ref_cnt.
  - 0x0A STATUS (R): bit0 done, bit1 busy, other bits 0.
  - 0x0B EDGES (R): edge_cnt.
- Bus outputs:
  - ack_o = stb_i & mapped address, combinational, zero wait states.
  - err_o = stb_i & unmapped address.
  - dat_o = selected register when stb_i & !we_i & mapped; otherwise 0.
- Writes commit on the clk_i edge where stb_i & we_i & addr==0x08.
  - Writes to read-only addresses are acked and ignored.
- CTRL bit0 (CLR), self-clearing: ref_cnt=0, edge_cnt=0, done=0, state→IDLE, from any state.
- CTRL bit7 (START): honoured only in IDLE or DONE.
  - Clears both counts and done, state→ARM.
  - Ignored while ARM or MEASURE.
  - If CLR and START are written together, CLR wins and START is ignored.
- signal_input passes through SYNC_STAGES flops; rise = synced & !synced_d.
- FSM:
  - IDLE: waits for START.
  - ARM: busy=1; on rise, ref_cnt=0, edge_cnt=0, →MEASURE.
  - MEASURE: busy=1.
    - Every cycle ref_cnt+=1, saturating at 0xFFFFFFFF.
    - On rise, edge_cnt+=1.
    - When that rise makes edge_cnt==GATE_EDGES, that cycle's increment is kept, done←1, →DONE.
  - DONE: holds results until CLR or START.
- Result: ref_cnt = clk_i cycles between the first rise and rise number GATE_EDGES after it. An exact period P cycles gives GATE_EDGES×P.
- signal_input stuck: the FSM stays in ARM or MEASURE indefinitely. Software recovers with CLR; no hardware timeout.
- Async reset mid-measurement returns all state to reset values immediately.

Decomposition:
- Package freq_counter_pkg: register address constants, CTRL bit indices, FSM state enum.
- One sub-module: freq_sync_edge (synchronizer plus rising-edge detector).

Test Plan:
- Reset: rst_i=1 for 100 ns → dat_o=0, ack_o=0, err_o=0, rty_o=0, tagn_o=0; STATUS reads 0.
- Basic measurement: clk 100 MHz, signal period 80 ns, write CTRL=0x01, then CTRL=0x80 → STATUS busy within 2 cycles. Within 1200 ns STATUS=0x1, RESULT (0x09)=64, EDGES=8.
- Re-measure: repeat CLR then START, reading RESULT=0 after CLR → second RESULT=64 again.
- START during MEASURE → ignored; final RESULT still 64. CLR during MEASURE → RESULT=0, STATUS=0.
- Bus: read of 0x20 → err_o=1, ack_o=0, dat_o=0; read of 0x09 with cyc_i=0 → ack_o=1 in the same cycle.
- No signal edges after START → STATUS busy stays 1 for 10 µs; CLR returns STATUS to 0.

Source files
------------

// File: rtl/freq_counter_wb_pkg.sv
// ============================================================================
// freq_counter_pkg : register map, CTRL bits and FSM states of freq_counter_wb
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package freq_counter_pkg;

  localparam logic [31:0] C_ADDR_CTRL   = 32'h0000_0008;
  localparam logic [31:0] C_ADDR_RESULT = 32'h0000_0009;
  localparam logic [31:0] C_ADDR_STATUS = 32'h0000_000A;
  localparam logic [31:0] C_ADDR_EDGES  = 32'h0000_000B;

  localparam int C_CTRL_CLR   = 0;
  localparam int C_CTRL_START = 7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/freq_counter_wb_if.sv
// ============================================================================
// freq_counter_wb_if : Wishbone-style slave bus bundle for freq_counter_wb
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface freq_counter_wb_if;
  logic [31:0] addr_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        we_i;
  logic [3:0]  sel_i;
  logic        cyc_i;
  logic        stb_i;
  logic        lock_i;
  logic        err_o;
  logic        rty_o;
  logic        ack_o;
  logic        tagn_i;
  logic        tagn_o;

  modport slave (
    input  addr_i, dat_i, we_i, sel_i, cyc_i, stb_i, lock_i, tagn_i,
    output dat_o, err_o, rty_o, ack_o, tagn_o
  );

  modport master (
    output addr_i, dat_i, we_i, sel_i, cyc_i, stb_i, lock_i, tagn_i,
    input  dat_o, err_o, rty_o, ack_o, tagn_o
  );
endinterface

`default_nettype wire

// File: rtl/freq_counter_wb_sync_edge.sv
// ============================================================================
// freq_sync_edge : multi-flop synchronizer followed by a rising-edge detector
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module freq_sync_edge
  import freq_counter_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic async_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced_d_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q     <= '0;
      synced_d_q <= 1'b0;
    end else begin
      sync_q[0] <= async_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      synced_d_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~synced_d_q;

endmodule

`default_nettype wire

// File: rtl/freq_counter_wb.sv
// ============================================================================
// freq_counter_wb : reciprocal frequency counter (clk_i cycles per GATE_EDGES
//                   periods of signal_input) with a memory-mapped bus slave
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module freq_counter_wb
  import freq_counter_pkg::*;
#(
  parameter int GATE_EDGES  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  freq_counter_wb_if.slave  wb,
  input  logic              signal_input,
  input  logic              reference_clk_main,
  input  logic              reference_clk_interpolate
);

  localparam logic [7:0] C_GATE = 8'(GATE_EDGES);

  state_e      state_q;
  logic [31:0] ref_cnt_q;
  logic [31:0] ref_cnt_d;
  logic [7:0]  edge_cnt_q;
  logic [7:0]  edge_cnt_d;
  logic        done_q;
  logic        tagn_q;
  logic        w_rise;
  logic        w_busy;
  logic        w_mapped;
  logic        w_wr_ctrl;
  logic        w_clr;
  logic        w_start;
  logic [31:0] w_rdata;
  logic        unused_inputs;

  freq_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .async_i (signal_input),
    .rise_o  (w_rise)
  );

  assign w_busy     = (state_q == ST_ARM) || (state_q == ST_MEASURE);
  assign w_mapped   = (wb.addr_i == C_ADDR_CTRL)   || (wb.addr_i == C_ADDR_RESULT) ||
                      (wb.addr_i == C_ADDR_STATUS) || (wb.addr_i == C_ADDR_EDGES);
  assign w_wr_ctrl  = wb.stb_i && wb.we_i && (wb.addr_i == C_ADDR_CTRL);
  assign w_clr      = w_wr_ctrl && wb.dat_i[C_CTRL_CLR];
  // CLR takes precedence when both bits are written together
  assign w_start    = w_wr_ctrl && wb.dat_i[C_CTRL_START] && !wb.dat_i[C_CTRL_CLR];
  assign ref_cnt_d  = (ref_cnt_q == 32'hFFFF_FFFF) ? ref_cnt_q : ref_cnt_q + 32'd1;
  assign edge_cnt_d = edge_cnt_q + 8'd1;

  always_comb begin
    w_rdata = '0;
    case (wb.addr_i)
      C_ADDR_RESULT: w_rdata = ref_cnt_q;
      C_ADDR_STATUS: w_rdata = {30'd0, w_busy, done_q};
      C_ADDR_EDGES:  w_rdata = {24'd0, edge_cnt_q};
      default:       w_rdata = '0;
    endcase
  end

  assign wb.ack_o  = wb.stb_i && w_mapped;
  assign wb.err_o  = wb.stb_i && !w_mapped;
  assign wb.rty_o  = 1'b0;
  assign wb.dat_o  = (wb.stb_i && !wb.we_i && w_mapped) ? w_rdata : 32'd0;
  assign wb.tagn_o = tagn_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      ref_cnt_q  <= '0;
      edge_cnt_q <= '0;
      done_q     <= 1'b0;
      tagn_q     <= 1'b0;
    end else begin
      tagn_q <= wb.tagn_i;
      if (w_clr) begin
        state_q    <= ST_IDLE;
        ref_cnt_q  <= '0;
        edge_cnt_q <= '0;
        done_q     <= 1'b0;
      end else if (w_start && !w_busy) begin
        state_q    <= ST_ARM;
        ref_cnt_q  <= '0;
        edge_cnt_q <= '0;
        done_q     <= 1'b0;
      end else begin
        case (state_q)
          ST_ARM: begin
            if (w_rise) begin
              ref_cnt_q  <= '0;
              edge_cnt_q <= '0;
              state_q    <= ST_MEASURE;
            end
          end
          ST_MEASURE: begin
            ref_cnt_q <= ref_cnt_d;
            if (w_rise) begin
              edge_cnt_q <= edge_cnt_d;
              if (edge_cnt_d == C_GATE) begin
                done_q  <= 1'b1;
                state_q <= ST_DONE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign unused_inputs = ^{wb.sel_i, wb.cyc_i, wb.lock_i, wb.dat_i[31:8], wb.dat_i[6:1],
                           reference_clk_main, reference_clk_interpolate};

endmodule

`default_nettype wire

// File: tb/tb_freq_counter_wb.sv
// ============================================================================
// tb_freq_counter_wb : directed + randomized-period bench for freq_counter_wb
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_freq_counter_wb;
  import freq_counter_pkg::*;

  localparam int GATE = 8;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic signal_input = 1'b0;
  logic ref_main = 1'b0;
  logic ref_interp = 1'b0;

  int checks = 0;
  int errors = 0;

  int unsigned sig_period = 8;
  int unsigned sig_high   = 4;
  bit          sig_en     = 1'b0;

  freq_counter_wb_if bus ();

  freq_counter_wb #(
    .GATE_EDGES  (GATE),
    .SYNC_STAGES (2)
  ) dut (
    .clk_i                     (clk_i),
    .rst_i                     (rst_i),
    .wb                        (bus),
    .signal_input              (signal_input),
    .reference_clk_main        (ref_main),
    .reference_clk_interpolate (ref_interp)
  );

  always #5 clk_i = ~clk_i;

  // Signal source with an exact period in clk_i units, offset 3 ns from the clock grid
  initial begin
    #3;
    forever begin
      if (!sig_en) begin
        signal_input = 1'b0;
        #10;
      end else begin
        signal_input = 1'b1;
        #(sig_high * 10);
        signal_input = 1'b0;
        #((sig_period - sig_high) * 10);
      end
    end
  end

  // Reference model: an exact period of P clocks yields GATE*P counted cycles
  function automatic logic [31:0] model_result(int unsigned p);
    return 32'(GATE * p);
  endfunction

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_read(input logic [31:0] a, input logic cyc,
                          output logic [31:0] d, output logic ack, output logic err);
    @(negedge clk_i);
    bus.addr_i = a;
    bus.we_i   = 1'b0;
    bus.cyc_i  = cyc;
    bus.stb_i  = 1'b1;
    #1;
    d   = bus.dat_o;
    ack = bus.ack_o;
    err = bus.err_o;
    @(posedge clk_i);
    #1;
    bus.stb_i = 1'b0;
    bus.cyc_i = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, output logic ack);
    @(negedge clk_i);
    bus.addr_i = a;
    bus.dat_i  = d;
    bus.we_i   = 1'b1;
    bus.cyc_i  = 1'b1;
    bus.stb_i  = 1'b1;
    #1;
    ack = bus.ack_o;
    @(posedge clk_i);
    #1;
    bus.stb_i = 1'b0;
    bus.we_i  = 1'b0;
    bus.cyc_i = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic ack, err;
    bus_read(a, 1'b1, d, ack, err);
    check32(tag, d, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic ack;
    bus_write(a, d, ack);
  endtask

  task automatic wait_status_bit(input int bitn, input int budget, output bit ok);
    logic [31:0] d;
    logic ack, err;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      bus_read(C_ADDR_STATUS, 1'b1, d, ack, err);
      if (d[bitn]) ok = 1'b1;
    end
  endtask

  task automatic wait_edges(input int unsigned n, input int budget, output bit ok);
    logic [31:0] d;
    logic ack, err;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      bus_read(C_ADDR_EDGES, 1'b1, d, ack, err);
      if (d >= n) ok = 1'b1;
    end
  endtask

  task automatic set_signal(input int unsigned p, input int unsigned h, input bit en);
    sig_en = 1'b0;
    #200;
    sig_period = p;
    sig_high   = h;
    sig_en     = en;
    repeat (3 * p + 5) @(posedge clk_i);
  endtask

  task automatic measure(input string tag, input int unsigned p, input int unsigned h);
    bit ok;
    set_signal(p, h, 1'b1);
    wr(C_ADDR_CTRL, 32'h01);
    read_check({tag, "_result_after_clr"}, C_ADDR_RESULT, 32'd0);
    wr(C_ADDR_CTRL, 32'h80);
    wait_status_bit(1, 2, ok);
    check32({tag, "_busy_after_start"}, 32'(ok), 32'd1);
    wait_status_bit(0, GATE * p + 3 * p + 20, ok);
    check32({tag, "_done_in_time"}, 32'(ok), 32'd1);
    read_check({tag, "_status"}, C_ADDR_STATUS, 32'h1);
    read_check({tag, "_result"}, C_ADDR_RESULT, model_result(p));
    read_check({tag, "_edges"}, C_ADDR_EDGES, 32'(GATE));
  endtask

  initial begin
    logic [31:0] d;
    logic ack, err;
    bit ok;
    int unsigned p, h;

    bus.addr_i = '0;
    bus.dat_i  = '0;
    bus.we_i   = 1'b0;
    bus.sel_i  = 4'hF;
    bus.cyc_i  = 1'b0;
    bus.stb_i  = 1'b0;
    bus.lock_i = 1'b0;
    bus.tagn_i = 1'b1;

    // Reset state
    #50;
    check32("rst_dat_o", bus.dat_o, 32'd0);
    check32("rst_ack_o", 32'(bus.ack_o), 32'd0);
    check32("rst_err_o", 32'(bus.err_o), 32'd0);
    check32("rst_rty_o", 32'(bus.rty_o), 32'd0);
    check32("rst_tagn_o", 32'(bus.tagn_o), 32'd0);
    #50;
    rst_i = 1'b0;
    read_check("rst_status", C_ADDR_STATUS, 32'd0);
    read_check("rst_result", C_ADDR_RESULT, 32'd0);
    read_check("rst_edges", C_ADDR_EDGES, 32'd0);

    // Tag passthrough
    @(posedge clk_i); #1;
    check32("tagn_high", 32'(bus.tagn_o), 32'd1);
    bus.tagn_i = 1'b0;
    @(posedge clk_i); #1;
    check32("tagn_low", 32'(bus.tagn_o), 32'd0);

    measure("basic", 8, 4);
    measure("remeasure", 8, 4);
    for (int k = 0; k < 4; k++) begin
      p = $urandom_range(12, 2);
      h = $urandom_range(p - 1, 1);
      measure($sformatf("rand%0d_p%0d", k, p), p, h);
    end

    // START while measuring is ignored
    set_signal(8, 3, 1'b1);
    wr(C_ADDR_CTRL, 32'h01);
    wr(C_ADDR_CTRL, 32'h80);
    wait_edges(2, 200, ok);
    check32("midstart_edges_seen", 32'(ok), 32'd1);
    wr(C_ADDR_CTRL, 32'h80);
    wait_status_bit(0, 200, ok);
    check32("midstart_done", 32'(ok), 32'd1);
    read_check("midstart_result", C_ADDR_RESULT, model_result(8));

    // CLR while measuring aborts
    wr(C_ADDR_CTRL, 32'h80);
    wait_edges(2, 200, ok);
    check32("midclr_edges_seen", 32'(ok), 32'd1);
    wr(C_ADDR_CTRL, 32'h01);
    read_check("midclr_result", C_ADDR_RESULT, 32'd0);
    read_check("midclr_status", C_ADDR_STATUS, 32'd0);
    read_check("midclr_edges", C_ADDR_EDGES, 32'd0);

    // CLR and START together: CLR wins
    wr(C_ADDR_CTRL, 32'h81);
    read_check("clrstart_status", C_ADDR_STATUS, 32'd0);

    // Bus decode
    bus_read(32'h20, 1'b1, d, ack, err);
    check32("unmapped_err", 32'(err), 32'd1);
    check32("unmapped_ack", 32'(ack), 32'd0);
    check32("unmapped_dat", d, 32'd0);
    bus_read(32'h108, 1'b1, d, ack, err);
    check32("fulldecode_err", 32'(err), 32'd1);
    bus_read(C_ADDR_RESULT, 1'b0, d, ack, err);
    check32("nocyc_ack", 32'(ack), 32'd1);
    bus_write(C_ADDR_RESULT, 32'hDEAD_BEEF, ack);
    check32("ro_write_ack", 32'(ack), 32'd1);
    read_check("ro_write_ignored", C_ADDR_RESULT, 32'd0);

    // Stuck input: busy persists until CLR
    set_signal(8, 4, 1'b0);
    wr(C_ADDR_CTRL, 32'h80);
    for (int k = 0; k < 5; k++) begin
      repeat (200) @(posedge clk_i);
      read_check($sformatf("stuck_busy%0d", k), C_ADDR_STATUS, 32'h2);
    end
    wr(C_ADDR_CTRL, 32'h01);
    read_check("stuck_clr_status", C_ADDR_STATUS, 32'd0);

    // Asynchronous reset mid-measurement
    set_signal(8, 4, 1'b1);
    wr(C_ADDR_CTRL, 32'h80);
    wait_edges(2, 200, ok);
    check32("arst_edges_seen", 32'(ok), 32'd1);
    #3 rst_i = 1'b1;
    #1;
    bus.addr_i = C_ADDR_RESULT;
    bus.stb_i  = 1'b1;
    #1;
    check32("arst_result_in_reset", bus.dat_o, 32'd0);
    bus.addr_i = C_ADDR_STATUS;
    #1;
    check32("arst_status_in_reset", bus.dat_o, 32'd0);
    bus.stb_i = 1'b0;
    #30 rst_i = 1'b0;
    read_check("arst_status_after", C_ADDR_STATUS, 32'd0);
    read_check("arst_edges_after", C_ADDR_EDGES, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
